// File: rtl/cordic_atanh_seq.sv
// Sequencer for hyperbolic CORDIC: steps through shift indices i = 1..ITERS and
// emits round(atanh(2^-i) * 2^FRAC) for each, repeating i = 4 and i = 13 when
// REPEAT_EN is set, as hyperbolic CORDIC needs for convergence. Each step is
// handed over with a valid/ready handshake.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   start_i       one-cycle request to begin a sequence (ignored while busy)
//   step_ready_i  consumer accepts the current step this cycle
//   busy_o        sequence in progress (RUN or FIN)
//   step_valid_o  shift_idx_o / atanh_val_o hold a valid step
//   shift_idx_o   current shift index i
//   atanh_val_o   atanh(2^-i) in unsigned fixed point, FRAC fractional bits
//   rep_flag_o    current step is the repeated instance of its index
//   last_o        current step is the final step of the sequence
//   done_o        one-cycle pulse after the final step is accepted
module cordic_atanh_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC      = 24,
  parameter int unsigned ITERS     = 16,
  parameter int unsigned REPEAT_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             step_ready_i,
  output logic             busy_o,
  output logic             step_valid_o,
  output logic [4:0]       shift_idx_o,
  output logic [WIDTH-1:0] atanh_val_o,
  output logic             rep_flag_o,
  output logic             last_o,
  output logic             done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  localparam logic [4:0]  LastIdx      = 5'(ITERS);
  // When ITERS is itself a repeat index, only its second instance is last.
  localparam bit          LastIsRepeat = (REPEAT_EN != 0) && ((ITERS == 4) || (ITERS == 13));
  localparam int unsigned Drop         = 32 - FRAC;

  // atanh(2^-i) at 32 fractional bits; from i = 11 on it equals 2^-i at this precision.
  function automatic logic [31:0] master_lut(input logic [4:0] idx);
    logic [31:0] m;
    case (idx)
      5'd1:    m = 32'h8C9F53D5;
      5'd2:    m = 32'h4162BBEA;
      5'd3:    m = 32'h202B1239;
      5'd4:    m = 32'h1005588B;
      5'd5:    m = 32'h0800AAC4;
      5'd6:    m = 32'h04001556;
      5'd7:    m = 32'h020002AB;
      5'd8:    m = 32'h01000055;
      5'd9:    m = 32'h0080000B;
      5'd10:   m = 32'h00400001;
      5'd11:   m = 32'h00200000;
      5'd12:   m = 32'h00100000;
      5'd13:   m = 32'h00080000;
      5'd14:   m = 32'h00040000;
      5'd15:   m = 32'h00020000;
      5'd16:   m = 32'h00010000;
      5'd17:   m = 32'h00008000;
      5'd18:   m = 32'h00004000;
      5'd19:   m = 32'h00002000;
      5'd20:   m = 32'h00001000;
      5'd21:   m = 32'h00000800;
      5'd22:   m = 32'h00000400;
      5'd23:   m = 32'h00000200;
      5'd24:   m = 32'h00000100;
      5'd25:   m = 32'h00000080;
      5'd26:   m = 32'h00000040;
      5'd27:   m = 32'h00000020;
      5'd28:   m = 32'h00000010;
      5'd29:   m = 32'h00000008;
      5'd30:   m = 32'h00000004;
      default: m = 32'h00000000;
    endcase
    return m;
  endfunction

  // Round half-up from 32 to FRAC fractional bits; 33 bits so the carry cannot be lost.
  function automatic logic [WIDTH-1:0] round_frac(input logic [31:0] m);
    logic [32:0] sum;
    sum = {1'b0, m} + (33'd1 << (Drop - 1));
    sum = sum >> Drop;
    return sum[WIDTH-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic             rep_q, rep_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             at_rep_point;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rep_d        = rep_q;
    at_rep_point = (REPEAT_EN != 0) && !rep_q && ((idx_q == 5'd4) || (idx_q == 5'd13));

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          idx_d   = 5'd1;
          rep_d   = 1'b0;
        end
      end
      StRun: begin
        if (step_ready_i) begin
          if (last_q) begin
            state_d = StFin;
            idx_d   = '0;
            rep_d   = 1'b0;
          end else if (at_rep_point) begin
            rep_d = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
            rep_d = 1'b0;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Step outputs are derived from the next index so they can be registered.
    last_d = (state_d == StRun) && (idx_d == LastIdx) && (!LastIsRepeat || rep_d);
    val_d  = (state_d == StRun) ? round_frac(master_lut(idx_d)) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      rep_q   <= 1'b0;
      last_q  <= 1'b0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      last_q  <= last_d;
      val_q   <= val_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign step_valid_o = (state_q == StRun);
  assign done_o       = (state_q == StFin);
  assign shift_idx_o  = idx_q;
  assign atanh_val_o  = val_q;
  assign rep_flag_o   = rep_q;
  assign last_o       = last_q;

endmodule
